// File: rtl/softproc_debug_mon_access.sv
// softproc_debug_mon_access: sysclk-side monitor memory access sequencer for the JTAG debug slave
module softproc_debug_mon_access #(
  parameter int          ADDR_W         = 8,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] cnt;
  logic [31:0] wdata;
  logic any_stb, acc, tmo, start_rd, start_wr, load_a, rd_done, wr_done, unused_jdo;
  assign unused_jdo = ^jdo;
  assign mem_address = addr;
  assign mem_writedata = wdata;
  assign mem_read = state == RD_REQ;
  assign mem_write = state == WR_REQ;
  assign busy = state != IDLE;
  // Command decode with b > a > no_action priority; timeout overrides any completion in the same cycle
  always_comb begin
    any_stb = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    acc = (state == RD_REQ || state == WR_REQ) && !mem_waitrequest;
    tmo = state != IDLE && cnt == CW'(TIMEOUT_CYCLES - 1);
    start_wr = state == IDLE && take_action_ocimem_b;
    load_a = state == IDLE && take_action_ocimem_a && !take_action_ocimem_b;
    start_rd = state == IDLE && !take_action_ocimem_b &&
               (take_action_ocimem_a ? jdo[34] : take_no_action_ocimem_a);
    rd_done = !tmo && mem_readdatavalid && (state == RD_WAIT || (state == RD_REQ && acc));
    wr_done = !tmo && state == WR_REQ && acc;
    state_n = (tmo || rd_done || wr_done) ? IDLE :
              start_wr ? WR_REQ :
              start_rd ? RD_REQ :
              (state == RD_REQ && acc) ? RD_WAIT : state;
  end
  // State register; async reset drops any request in flight at once
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // Address, timeout counter, write data and monitor result registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      MonDReg <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      addr <= load_a ? jdo[17 +: ADDR_W] : (rd_done || wr_done) ? addr + 1'b1 : addr;
      wdata <= start_wr ? jdo[34:3] : wdata;
      MonDReg <= rd_done ? mem_readdata : (tmo && state != WR_REQ) ? ERR_DATA : MonDReg;
      monitor_ready <= (start_rd || start_wr) ? 1'b0 : (rd_done || wr_done || tmo) ? 1'b1 : monitor_ready;
      monitor_error <= ((busy && any_stb) || tmo) ? 1'b1 : load_a ? 1'b0 : monitor_error;
    end
endmodule

// File: tb/tb_softproc_debug_mon_access.sv
// tb_softproc_debug_mon_access: scoreboard bench with a wait-state slave model
module tb_softproc_debug_mon_access;
  logic clk = 0;
  logic reset_n;
  logic [37:0] jdo;
  logic take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0] mem_address;
  logic mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic mem_waitrequest;
  logic [31:0] mem_readdata;
  logic mem_readdatavalid;
  logic [31:0] MonDReg;
  logic monitor_ready, monitor_error, busy;

  typedef struct {bit wr; logic [7:0] addr; logic [31:0] data;} acc_t;
  acc_t exp_q[$];
  int tests = 0, fails = 0;
  int rd_cycles = 0, wr_cycles = 0;
  int ws = 0, ws_cnt = 0;
  bit hang = 0, hold_rdv = 0, late_rdv = 0;
  logic [31:0] slave_data = 0, rd_q = 0;
  logic rdv_q = 0;

  softproc_debug_mon_access dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_waitrequest = hang || ((mem_read || mem_write) && ws_cnt < ws);
  assign mem_readdatavalid = rdv_q | late_rdv;
  assign mem_readdata = late_rdv ? 32'h0BAD0BAD : rd_q;

  always @(posedge clk) begin
    rdv_q <= mem_read && !mem_waitrequest && !hold_rdv;
    rd_q <= slave_data;
    ws_cnt <= ((mem_read || mem_write) && mem_waitrequest) ? ws_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cycles++;
    if (mem_write) wr_cycles++;
    if ((mem_read || mem_write) && !mem_waitrequest) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL access: unexpected wr=%0b addr=%h data=%h", mem_write, mem_address, mem_writedata);
      end else begin
        acc_t e;
        e = exp_q.pop_front();
        if ({mem_write, mem_address, (mem_write ? mem_writedata : 32'h0)} !== {e.wr, e.addr, e.data}) begin
          fails++;
          $display("FAIL access: got wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                   mem_write, mem_address, mem_write ? mem_writedata : 32'h0, e.wr, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [37:0] mk_a(input logic [7:0] a, input bit rd);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    return j;
  endfunction

  task automatic strobe(input bit a, input bit na, input bit b, input logic [37:0] j);
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    jdo = j;
    @(posedge clk); #1;
    take_action_ocimem_a = 0;
    take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0;
    jdo = '0;
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mem_read, mem_write, busy, monitor_ready, monitor_error} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", {mem_read, mem_write, busy, monitor_ready, monitor_error});
    end
    tests++;
    if ({MonDReg, mem_address, mem_writedata} !== 72'h0) begin
      fails++;
      $display("FAIL reset_data: got MonDReg=%h addr=%h wdata=%h expected zeros", MonDReg, mem_address, mem_writedata);
    end
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_load;
    int n;
    slave_data = 32'h12345678;
    rd_cycles = 0;
    exp_q.push_back('{0, 8'h10, 32'h0});
    strobe(1, 0, 0, mk_a(8'h10, 1));
    wait_idle(20, n);
    tests++;
    if (n !== 2) begin fails++; $display("FAIL read_latency: got %0d edges expected 2", n); end
    tests++;
    if (MonDReg !== 32'h12345678) begin fails++; $display("FAIL read_data: got %h expected 12345678", MonDReg); end
    tests++;
    if ({monitor_ready, mem_address} !== {1'b1, 8'h11}) begin
      fails++; $display("FAIL read_ready_addr: got %b/%h expected 1/11", monitor_ready, mem_address);
    end
    tests++;
    if (rd_cycles !== 1) begin fails++; $display("FAIL read_pulse: got %0d cycles expected 1", rd_cycles); end
  endtask

  task automatic test_write_wait;
    int n;
    ws = 3;
    wr_cycles = 0;
    exp_q.push_back('{1, 8'h11, 32'hCAFEF00D});
    strobe(0, 0, 1, {3'b0, 32'hCAFEF00D, 3'b0});
    wait_idle(20, n);
    tests++;
    if (n !== 4) begin fails++; $display("FAIL write_latency: got %0d edges expected 4", n); end
    tests++;
    if (wr_cycles !== 4) begin fails++; $display("FAIL write_hold: got %0d cycles expected 4", wr_cycles); end
    tests++;
    if ({monitor_ready, mem_address} !== {1'b1, 8'h12}) begin
      fails++; $display("FAIL write_ready_addr: got %b/%h expected 1/12", monitor_ready, mem_address);
    end
    ws = 0;
  endtask

  task automatic test_wrap;
    int n;
    logic [7:0] a;
    strobe(1, 0, 0, mk_a(8'hFF, 0));
    tests++;
    if ({busy, monitor_ready, mem_address} !== {1'b0, 1'b1, 8'hFF}) begin
      fails++; $display("FAIL addr_load: got busy=%b ready=%b addr=%h expected 0/1/ff", busy, monitor_ready, mem_address);
    end
    a = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      slave_data = 32'hA0000000 + i;
      exp_q.push_back('{0, a, 32'h0});
      strobe(0, 1, 0, '0);
      wait_idle(20, n);
      tests++;
      if ({n, MonDReg} !== {32'd2, 32'hA0000000 + i}) begin
        fails++; $display("FAIL wrap_read%0d: got n=%0d data=%h expected n=2 data=%h", i, n, MonDReg, 32'hA0000000 + i);
      end
      a = a + 8'h1;
    end
    tests++;
    if (mem_address !== 8'h02) begin fails++; $display("FAIL wrap_addr: got %h expected 02", mem_address); end
  endtask

  task automatic test_timeout;
    int n;
    hang = 1;
    strobe(0, 1, 0, '0);
    wait_idle(400, n);
    hang = 0;
    tests++;
    if (n !== 255) begin fails++; $display("FAIL timeout_len: got %0d edges expected 255", n); end
    tests++;
    if ({MonDReg, monitor_error, monitor_ready, mem_address} !== {32'hDEADBEEF, 1'b1, 1'b1, 8'h02}) begin
      fails++; $display("FAIL timeout_state: got %h/%b/%b/%h expected deadbeef/1/1/02", MonDReg, monitor_error, monitor_ready, mem_address);
    end
    late_rdv = 1;
    @(posedge clk); #1;
    late_rdv = 0;
    @(posedge clk); #1;
    tests++;
    if ({MonDReg, busy, mem_address} !== {32'hDEADBEEF, 1'b0, 8'h02}) begin
      fails++; $display("FAIL late_rdv: got %h/%b/%h expected deadbeef/0/02", MonDReg, busy, mem_address);
    end
    strobe(1, 0, 0, mk_a(8'h20, 0));
    tests++;
    if ({monitor_error, mem_address} !== {1'b0, 8'h20}) begin
      fails++; $display("FAIL error_clear: got %b/%h expected 0/20", monitor_error, mem_address);
    end
  endtask

  task automatic test_priority_overrun;
    int n;
    rd_cycles = 0;
    exp_q.push_back('{1, 8'h20, 32'hA5A55A5A});
    strobe(1, 0, 1, {3'b0, 32'hA5A55A5A, 3'b0});
    wait_idle(20, n);
    tests++;
    if ({n, mem_address, monitor_error} !== {32'd1, 8'h21, 1'b0}) begin
      fails++; $display("FAIL priority: got n=%0d addr=%h err=%b expected 1/21/0", n, mem_address, monitor_error);
    end
    ws = 5;
    exp_q.push_back('{1, 8'h21, 32'h0F0FF0F0});
    strobe(0, 0, 1, {3'b0, 32'h0F0FF0F0, 3'b0});
    strobe(0, 1, 0, '0);
    tests++;
    if ({busy, monitor_error} !== 2'b11) begin
      fails++; $display("FAIL overrun_err: got busy=%b err=%b expected 1/1", busy, monitor_error);
    end
    wait_idle(20, n);
    tests++;
    if ({n, mem_address, monitor_ready, monitor_error} !== {32'd5, 8'h22, 1'b1, 1'b1}) begin
      fails++; $display("FAIL overrun_done: got n=%0d addr=%h rdy=%b err=%b expected 5/22/1/1", n, mem_address, monitor_ready, monitor_error);
    end
    tests++;
    if (rd_cycles !== 0) begin fails++; $display("FAIL no_read: got %0d read cycles expected 0", rd_cycles); end
    ws = 0;
  endtask

  task automatic test_reset_mid;
    hold_rdv = 1;
    exp_q.push_back('{0, 8'h22, 32'h0});
    strobe(0, 1, 0, '0);
    @(posedge clk); #1;
    tests++;
    if ({busy, mem_read} !== 2'b10) begin
      fails++; $display("FAIL rd_wait: got busy=%b rd=%b expected 1/0", busy, mem_read);
    end
    #2 reset_n = 0;
    #1;
    tests++;
    if ({mem_read, mem_write, busy, monitor_ready, monitor_error, MonDReg, mem_address} !== 45'h0) begin
      fails++; $display("FAIL async_reset: got rd=%b wr=%b busy=%b rdy=%b err=%b data=%h addr=%h expected zeros",
                        mem_read, mem_write, busy, monitor_ready, monitor_error, MonDReg, mem_address);
    end
    @(posedge clk); #1;
    reset_n = 1;
    hold_rdv = 0;
    rd_cycles = 0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if ({rd_cycles, busy, monitor_ready} !== {32'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL no_replay: got rd_cycles=%0d busy=%b rdy=%b expected 0/0/0", rd_cycles, busy, monitor_ready);
    end
  endtask

  initial begin
    reset_n = 0;
    jdo = '0;
    take_action_ocimem_a = 0;
    take_no_action_ocimem_a = 0;
    take_action_ocimem_b = 0;
    test_reset();
    test_read_load();
    test_write_wait();
    test_wrap();
    test_timeout();
    test_priority_overrun();
    test_reset_mid();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d expected accesses never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/softproc_debug_mon_access.md
Name: softproc_debug_mon_access

Overview:
- Sysclk-domain monitor-memory access sequencer, directly downstream of the CPU debug-slave wrapper.
- Consumes the wrapper's jdo word and its ocimem take-action strobes.
- Executes word reads and writes on a simple memory master port.
- Returns MonDReg, monitor_ready and monitor_error to the wrapper's tck side, closing the JTAG monitor-access loop.

Parameters:
ADDR_W, 8, word-address width of the monitor memory port (1..16)
TIMEOUT_CYCLES, 255, cycles allowed per access, counted from command acceptance, before abort
ERR_DATA, 32'hDEADBEEF, value loaded into MonDReg on an aborted read

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  debug command/data word from the wrapper
take_action_ocimem_a  in  1  1-cycle strobe: address-load command
take_no_action_ocimem_a  in  1  1-cycle strobe: streaming read at the current address
take_action_ocimem_b  in  1  1-cycle strobe: write command
mem_address  out  ADDR_W  word address
mem_read  out  1  read request, held until accepted
mem_write  out  1  write request, held until accepted
mem_writedata  out  32  write data
mem_waitrequest  in  1  slave stall; a request is accepted in a cycle where it is asserted and waitrequest is 0
mem_readdata  in  32  read data
mem_readdatavalid  in  1  read data valid, one cycle per accepted read
MonDReg  out  32  last read data, or ERR_DATA after an abort
monitor_ready  out  1  1 = no access in flight; result valid
monitor_error  out  1  sticky error flag
busy  out  1  1 while state != IDLE

Behaviour:
- Reset: all outputs are 0 (MonDReg=0, mem_address=0). State is IDLE. The address register and timeout counter are 0.
- Reset is asynchronous. Reset asserted mid-access drops mem_read and mem_write immediately. After reset, no pending access is replayed.
- Command decode (all commands sampled in IDLE only):
  - ocimem_a: address register <= jdo[17+ADDR_W-1:17].
  - ocimem_a with jdo[34]=1: also start a read at the newly loaded address.
  - ocimem_a with jdo[34]=0: address load only. monitor_ready is unchanged.
  - take_no_action_ocimem_a: start a read at the current address.
  - ocimem_b: start a write of jdo[34:3] at the current address.
  - ocimem_a additionally clears monitor_error.
- Strobe priority when several strobes arrive in the same cycle: ocimem_b > ocimem_a > no_action_a. Lower-priority strobes are discarded silently.
- Any strobe arriving while busy=1 is discarded and sets monitor_error (overrun). The access in flight is unaffected.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE -> RD_REQ on a read start. IDLE -> WR_REQ on a write start.
  - Accepting a command clears monitor_ready and the timeout counter in the same edge. mem_read or mem_write rises on the next cycle.
  - RD_REQ: hold mem_read=1 until accepted, then go to RD_WAIT. If accepted and readdatavalid occur in the same cycle, capture immediately and go to IDLE.
  - RD_WAIT: on mem_readdatavalid, MonDReg <= mem_readdata, monitor_ready <= 1, address += 1, go to IDLE.
  - WR_REQ: hold mem_write=1 and mem_writedata until accepted. Then monitor_ready <= 1, address += 1, go to IDLE.
  - mem_address equals the address register throughout.
- Timeout: the counter increments every cycle while not in IDLE. When it reaches TIMEOUT_CYCLES-1:
  - drop the request, set monitor_error, set monitor_ready=1, go to IDLE;
  - on a read, MonDReg <= ERR_DATA;
  - the address register does not increment.
- mem_readdatavalid received in IDLE (a late response after an abort) is ignored.
- Address increment wraps modulo 2^ADDR_W (all-ones -> 0).
- Minimum latency, zero-wait slave, no stall:
  - read: strobe edge -> monitor_ready=1 after 3 clocks;
  - write: strobe edge -> monitor_ready=1 after 2 clocks.

Test Plan:
- Reset, then ocimem_a with jdo[24:17]=8'h10 and jdo[34]=1; slave returns 32'h12345678 with 0 wait states -> mem_read pulses 1 cycle at address 0x10; MonDReg=32'h12345678; monitor_ready=1; address=0x11.
- ocimem_b with jdo[34:3]=32'hCAFEF00D, waitrequest held 3 cycles -> mem_write high for 4 cycles with data CAFEF00D at 0x11; then monitor_ready=1 and address=0x12.
- Load address 0xFF, then issue three no_action_a reads -> accesses at 0xFF, 0x00, 0x01 (wrap-around verified).
- Slave holds waitrequest forever on a read -> abort after 255 cycles; MonDReg=DEADBEEF; monitor_error=1; address unchanged. A late readdatavalid is ignored. The next ocimem_a clears monitor_error.
- ocimem_b and ocimem_a asserted in the same cycle -> only the write executes. A no_action_a strobe issued while busy -> dropped and monitor_error=1.
- reset_n asserted while in RD_WAIT -> outputs 0 asynchronously. After release, state is IDLE and no mem_read is issued.
